// File: rtl/misr_bist_ctrl_pkg.sv
// Shared definitions for the MISR BIST controller: FSM state
// encoding and default signature / run-length widths.
package misr_bist_ctrl_pkg;

    localparam int DEF_W     = 120;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/misr_bist_ctrl_cycle_counter.sv
// bist_cycle_counter: run-length down-counter for the BIST controller.
// Ports: clk, reset_n, clr (sync zero), load/load_val, dec, count, last.
module bist_cycle_counter
    import misr_bist_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Decrement saturates at zero, so a full-scale load never wraps.
    assign count = cnt;
    assign last  = (cnt == CNT_W'(1));

endmodule

// File: rtl/misr_bist_ctrl.sv
// MISR BIST session controller: clears the MISR, runs the CUT for a
// programmed number of cycles, compares the signature with a golden value.
// Ports: clk, reset_n, start, abort, num_cycles, golden, misr_q (in);
//        misr_clr, misr_en, cut_run, busy, done, pass, sig_q (out).
// Option: MISR_BIST_SIG_CAPTURE_EN adds a signature capture register
//         on sig_q; otherwise sig_q is tied to zero.
module misr_bist_ctrl
    import misr_bist_ctrl_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [W:0]       golden,
    input  logic [W:0]       misr_q,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             cut_run,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [W:0]       sig_q
);

    state_t           state;
    state_t           state_nxt;
    logic [W:0]       golden_q;
    logic             pass_q;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_val;
    logic             kill;

    assign kill = abort && (state != ST_IDLE);

    bist_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (kill),
        .load     (state == ST_CLEAR),
        .load_val (num_cycles),
        .dec      (state == ST_RUN),
        .count    (cnt_val),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (num_cycles != '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_COMPARE;
                end
            end
            ST_RUN: begin
                if (cnt_last) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE:  state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (kill) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            golden_q <= '0;
        end else if (state == ST_CLEAR) begin
            golden_q <= golden;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_q <= 1'b0;
        end else if (kill || (state == ST_CLEAR)) begin
            pass_q <= 1'b0;
        end else if (state == ST_COMPARE) begin
            pass_q <= (misr_q == golden_q);
        end
    end

`ifdef MISR_BIST_SIG_CAPTURE_EN
    logic [W:0] sig_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_r <= '0;
        end else if (state == ST_CLEAR) begin
            sig_r <= '0;
        end else if ((state == ST_COMPARE) && !kill) begin
            sig_r <= misr_q;
        end
    end

    assign sig_q = sig_r;
`else
    assign sig_q = '0;
`endif

    // Counter value is only observed through its last flag.
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

    assign misr_clr = (state == ST_CLEAR);
    assign misr_en  = (state == ST_RUN);
    assign cut_run  = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign pass     = pass_q;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Self-checking bench for misr_bist_ctrl (W=3, CNT_W=8) with a
// 4-bit reference MISR (seed 1) acting as the compacted CUT.
module tb_misr_bist_ctrl;

    localparam int W     = 3;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_cycles;
    logic [W:0]       golden;
    logic [W:0]       misr_q;
    logic             misr_clr;
    logic             misr_en;
    logic             cut_run;
    logic             busy;
    logic             done;
    logic             pass;
    logic [W:0]       sig_q;

    int vectors;
    int miscompares;

    int         exp_lat[$];
    bit         exp_pass[$];
    logic [3:0] exp_sig[$];

    misr_bist_ctrl #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .num_cycles (num_cycles),
        .golden     (golden),
        .misr_q     (misr_q),
        .misr_clr   (misr_clr),
        .misr_en    (misr_en),
        .cut_run    (cut_run),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .sig_q      (sig_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pat_data(int i);
        int v;
        v = (i * 7 + 3) & 15;
        return 4'(v);
    endfunction

    function automatic logic [3:0] misr_next(logic [3:0] q,
                                             logic [3:0] d);
        return {q[2:0], q[3] ^ q[2]} ^ d;
    endfunction

    function automatic logic [3:0] ref_sig(int n);
        logic [3:0] q;
        q = 4'h1;
        for (int i = 0; i < n; i++) begin
            q = misr_next(q, pat_data(i));
        end
        return q;
    endfunction

    logic [3:0] env_q;
    int         env_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_q   <= 4'h1;
            env_idx <= 0;
        end else if (misr_clr) begin
            env_q   <= 4'h1;
            env_idx <= 0;
        end else if (misr_en) begin
            env_q   <= misr_next(env_q, pat_data(env_idx));
            env_idx <= env_idx + 1;
        end
    end

    assign misr_q = env_q;

    function automatic logic [3:0] sig_expect(logic [3:0] s);
`ifdef MISR_BIST_SIG_CAPTURE_EN
        return s;
`else
        return 4'h0 & s;
`endif
    endfunction

    task automatic test_reset();
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        num_cycles = '0;
        golden     = '0;
        #3;
        vectors++;
        if ({misr_clr, misr_en, cut_run, busy, done, pass, sig_q}
            !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=0",
                {misr_clr, misr_en, cut_run, busy, done, pass, sig_q});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic session(input int n, input bit flip,
                           input bit hold, input string name);
        int         cyc;
        int         n_clr;
        int         n_en;
        int         lat;
        bit         got;
        bit         ps;
        logic [3:0] sg;
        int         e_lat;
        bit         e_pass;
        logic [3:0] e_sig;
        int         b;

        exp_lat.push_back(n == 0 ? 3 : n + 4);
        exp_pass.push_back(!flip);
        exp_sig.push_back(sig_expect(ref_sig(n)));

        @(negedge clk);
        start      = 1'b1;
        num_cycles = CNT_W'(n);
        golden     = ref_sig(n) ^ {3'b000, flip};
        @(posedge clk);
        cyc   = 0;
        n_clr = 0;
        n_en  = 0;
        got   = 1'b0;
        lat   = 0;
        ps    = 1'b0;
        sg    = 4'h0;
        while (!got && cyc < n + 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) start = 1'b0;
            if (cyc == 2) begin
                num_cycles = 8'h03;
                golden     = ~golden;
            end
            if (misr_clr) n_clr++;
            if (misr_en && cut_run) n_en++;
            if (done) begin
                got = 1'b1;
                lat = cyc;
                ps  = pass;
                sg  = sig_q;
            end
        end
        if (hold) start = 1'b0;

        e_lat  = exp_lat.pop_front();
        e_pass = exp_pass.pop_front();
        e_sig  = exp_sig.pop_front();

        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s_done_timeout got=none exp=cycle %0d",
                name, e_lat);
        end else begin
            vectors++;
            if (lat !== e_lat) begin
                miscompares++;
                $display("FAIL %s_latency got=%0d exp=%0d",
                    name, lat, e_lat);
            end
            vectors++;
            if (ps !== e_pass) begin
                miscompares++;
                $display("FAIL %s_pass got=%0b exp=%0b",
                    name, ps, e_pass);
            end
            vectors++;
            if (sg !== e_sig) begin
                miscompares++;
                $display("FAIL %s_sig got=%h exp=%h", name, sg, e_sig);
            end
        end
        vectors++;
        if (n_clr !== 1) begin
            miscompares++;
            $display("FAIL %s_clr_cycles got=%0d exp=1", name, n_clr);
        end
        vectors++;
        if (n_en !== n) begin
            miscompares++;
            $display("FAIL %s_en_cycles got=%0d exp=%0d", name, n_en, n);
        end

        b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || misr_clr) b++;
        end
        vectors++;
        if (b !== 0) begin
            miscompares++;
            $display("FAIL %s_extra_session got=%0d exp=0", name, b);
        end
    endtask

    task automatic test_abort();
        int d;
        @(negedge clk);
        start      = 1'b1;
        num_cycles = 8'd5;
        golden     = ref_sig(5);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({misr_en, cut_run, busy, pass} !== 4'b0) begin
            miscompares++;
            $display("FAIL abort_outputs got=%b exp=0000",
                {misr_en, cut_run, busy, pass});
        end
        d = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) d++;
        end
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done got=%0d exp=0", d);
        end
    endtask

    task automatic test_start_abort_idle();
        int b;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        b = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy || misr_clr) b++;
        end
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (b !== 0) begin
            miscompares++;
            $display("FAIL idle_abort_wins got=%0d exp=0", b);
        end
    endtask

    task automatic test_reset_mid_run();
        int d;
        @(negedge clk);
        start      = 1'b1;
        num_cycles = 8'd5;
        golden     = ref_sig(5);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({misr_clr, misr_en, cut_run, busy, done, pass, sig_q}
            !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_mid_run got=%b exp=0",
                {misr_clr, misr_en, cut_run, busy, done, pass, sig_q});
        end
        @(negedge clk);
        reset_n = 1'b1;
        d = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) d++;
        end
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL reset_no_done got=%0d exp=0", d);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        session(5, 1'b0, 1'b0, "n5_pass");
        session(5, 1'b1, 1'b0, "n5_fail");
        session(0, 1'b0, 1'b0, "n0");
        session(7, 1'b0, 1'b1, "held_start");
        test_abort();
        session(5, 1'b0, 1'b0, "after_abort");
        test_start_abort_idle();
        session(255, 1'b0, 1'b0, "full_count");
        test_reset_mid_run();
        session(3, 1'b0, 1'b0, "after_reset");
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/misr_bist_ctrl.md
MISR_BIST_CTRL -- requirements
Module: misr_bist_ctrl

Interface
REQ-001 SHALL have parameter W, default 120: MSB index of signature bus (bus width W+1).
REQ-002 SHALL have parameter CNT_W, default 16: width of run-length counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one BIST session; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel current session.
REQ-007 SHALL have port num_cycles  input  CNT_W  compaction cycles; sampled in CLEAR.
REQ-008 SHALL have port golden  input  W+1  expected signature; sampled in CLEAR.
REQ-009 SHALL have port misr_q  input  W+1  current MISR signature.
REQ-010 SHALL have port misr_clr  output  1  active-high clear to MISR (loads seed).
REQ-011 SHALL have port misr_en  output  1  MISR compaction enable.
REQ-012 SHALL have port cut_run  output  1  enable for circuit-under-test/pattern source.
REQ-013 SHALL have ports busy, done, pass  output  1 each  session active; 1-cycle completion pulse; compare result.
REQ-014 SHALL have port sig_q  output  W+1  captured signature (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE, CLEAR, RUN, SETTLE, COMPARE, DONE; outputs Moore-decoded from state/registers.
REQ-016 IDLE: start=1 and abort=0 -> CLEAR; otherwise stay.
REQ-017 CLEAR: misr_clr=1 for exactly one cycle; latch num_cycles, golden; -> RUN if num_cycles!=0, else -> COMPARE.
REQ-018 RUN: misr_en=cut_run=1 for exactly num_cycles consecutive cycles (down-counter); last cycle -> SETTLE.
REQ-019 SETTLE: misr_en=0 for one cycle so final MISR update is visible on misr_q; -> COMPARE.
REQ-020 COMPARE: pass register <= (misr_q == latched golden), full W+1-bit compare; -> DONE.
REQ-021 DONE: done=1 for one cycle; -> IDLE. pass holds until next CLEAR or abort.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Latency: with start sampled at edge 0, done is high in cycle num_cycles+4 (cycle 3 when num_cycles=0).
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 abort=1 in any non-IDLE state -> IDLE next edge; misr_en/cut_run low from next cycle; pass cleared; done not pulsed.
REQ-026 abort and start both high in IDLE: abort wins, stay IDLE.
REQ-027 num_cycles=2^CNT_W-1 SHALL run full count without counter wrap.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, counter=0, misr_clr=misr_en=cut_run=busy=done=pass=0, sig_q=0.
REQ-029 Reset mid-session SHALL discard session; no done pulse after release.

Configuration
REQ-030 Macro MISR_BIST_SIG_CAPTURE_EN defined: sig_q loads misr_q in COMPARE and holds until next CLEAR (cleared there) or reset.
REQ-031 Macro undefined: sig_q tied to 0, no capture register; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold FSM state enum and default CNT_W/W constants.
REQ-033 Run-length down-counter SHALL be a sub-module bist_cycle_counter (load, decrement, last flag).

Verification (W=3, MISR seed 1, reference MISR model on bench)
REQ-034 reset_n low mid-RUN -> all outputs 0 immediately; no done after release.
REQ-035 num_cycles=5, golden=model signature -> misr_clr 1 cycle, misr_en exactly 5 cycles, done in cycle 9, pass=1.
REQ-036 num_cycles=5, golden bit0 inverted -> done in cycle 9, pass=0.
REQ-037 num_cycles=0, golden=4'h1 -> misr_en never high, done in cycle 3, pass=1.
REQ-038 abort during 3rd RUN cycle -> misr_en low next cycle, no done, pass=0; subsequent start completes normally.
REQ-039 start held high throughout session -> exactly one session; with MISR_BIST_SIG_CAPTURE_EN, sig_q equals misr_q at COMPARE.
